// File: rtl/alarm_sequencer.sv
// Alarm controller: conditions the button/sensor inputs, derives a 1 s tick and
// sequences IDLE -> SET -> TRIGGER -> ALERT, driving the display state and timer.
module alarm_sequencer #(
  parameter int CLK_HZ         = 50_000_000,
  parameter int ARM_DELAY_SECS = 10,
  parameter int TRIGGER_SECS   = 30
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       arm_btn,
  input  logic       disarm_btn,
  input  logic       sensor,
  output logic [1:0] system_state,
  output logic [7:0] timer,
  output logic       alarm_out,
  output logic       state_change
);

  typedef enum logic [1:0] {
    STATE_IDLE    = 2'd0,
    STATE_SET     = 2'd1,
    STATE_TRIGGER = 2'd2,
    STATE_ALERT   = 2'd3
  } fsm_state_t;

  localparam int                PRESC_W   = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(CLK_HZ - 1);
  localparam logic [PRESC_W-1:0] PRESC_ONE = PRESC_W'(1);
  localparam logic [PRESC_W-1:0] PRESC_ZERO = PRESC_W'(0);
  localparam logic [7:0]        ARM_LOAD  = 8'(ARM_DELAY_SECS);
  localparam logic [7:0]        TRIG_LOAD = 8'(TRIGGER_SECS);

  logic               r_arm_s1, r_arm_s2, r_arm_d, r_arm_ev;
  logic               r_dis_s1, r_dis_s2, r_dis_d, r_dis_ev;
  logic               r_sen_s1, r_sen_s2, r_sen_d;
  fsm_state_t         r_state;
  logic [7:0]         r_timer;
  logic               r_alarm;
  logic               r_state_change;
  logic [PRESC_W-1:0] r_presc;
  logic               w_tick;

  assign w_tick = (r_presc == PRESC_MAX);

  // Synchronise inputs and register one-cycle rising-edge events for the buttons
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_arm_s1 <= 1'b0; r_arm_s2 <= 1'b0; r_arm_d <= 1'b0; r_arm_ev <= 1'b0;
      r_dis_s1 <= 1'b0; r_dis_s2 <= 1'b0; r_dis_d <= 1'b0; r_dis_ev <= 1'b0;
      r_sen_s1 <= 1'b0; r_sen_s2 <= 1'b0; r_sen_d <= 1'b0;
    end else begin
      r_arm_s1 <= arm_btn;
      r_arm_s2 <= r_arm_s1;
      r_arm_d  <= r_arm_s2;
      r_arm_ev <= r_arm_s2 & ~r_arm_d;
      r_dis_s1 <= disarm_btn;
      r_dis_s2 <= r_dis_s1;
      r_dis_d  <= r_dis_s2;
      r_dis_ev <= r_dis_s2 & ~r_dis_d;
      r_sen_s1 <= sensor;
      r_sen_s2 <= r_sen_s1;
      r_sen_d  <= r_sen_s2;
    end
  end

  // State machine, timer and prescaler; every transition restarts the prescaler
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state        <= STATE_IDLE;
      r_timer        <= 8'd0;
      r_alarm        <= 1'b0;
      r_state_change <= 1'b0;
      r_presc        <= PRESC_ZERO;
    end else begin
      r_state_change <= 1'b0;
      r_presc        <= w_tick ? PRESC_ZERO : (r_presc + PRESC_ONE);
      case (r_state)
        STATE_IDLE: begin
          if (r_arm_ev && !r_dis_ev) begin
            r_state        <= STATE_SET;
            r_timer        <= ARM_LOAD;
            r_presc        <= PRESC_ZERO;
            r_state_change <= 1'b1;
          end else begin
            r_timer <= 8'd0;
          end
        end
        STATE_SET: begin
          if (r_dis_ev) begin
            r_state        <= STATE_IDLE;
            r_timer        <= 8'd0;
            r_presc        <= PRESC_ZERO;
            r_state_change <= 1'b1;
          end else if (r_timer != 8'd0) begin
            if (w_tick) begin
              r_timer <= r_timer - 8'd1;
            end
          end else if (r_sen_d) begin
            r_state        <= STATE_TRIGGER;
            r_timer        <= TRIG_LOAD;
            r_presc        <= PRESC_ZERO;
            r_state_change <= 1'b1;
          end
        end
        STATE_TRIGGER: begin
          if (r_dis_ev) begin
            r_state        <= STATE_IDLE;
            r_timer        <= 8'd0;
            r_presc        <= PRESC_ZERO;
            r_state_change <= 1'b1;
          end else if (w_tick && (r_timer <= 8'd1)) begin
            r_state        <= STATE_ALERT;
            r_timer        <= 8'd0;
            r_alarm        <= 1'b1;
            r_presc        <= PRESC_ZERO;
            r_state_change <= 1'b1;
          end else if (w_tick) begin
            r_timer <= r_timer - 8'd1;
          end
        end
        STATE_ALERT: begin
          r_timer <= 8'd0;
          if (r_dis_ev) begin
            r_state        <= STATE_IDLE;
            r_alarm        <= 1'b0;
            r_presc        <= PRESC_ZERO;
            r_state_change <= 1'b1;
          end
        end
        default: begin
          r_state        <= STATE_IDLE;
          r_timer        <= 8'd0;
          r_alarm        <= 1'b0;
          r_presc        <= PRESC_ZERO;
          r_state_change <= 1'b1;
        end
      endcase
    end
  end

  assign system_state = r_state;
  assign timer        = r_timer;
  assign alarm_out    = r_alarm;
  assign state_change = r_state_change;

endmodule
